// File: rtl/int_ctrl_n_if.sv
// Bus bundle for the IM2 interrupt controller: Z80 bus pins, register access
// port and acknowledge sideband.
interface int_ctrl_n_if #(
  parameter int NUM_INT = 8
);
  localparam int IDW = $clog2(NUM_INT);

  // Z80 side
  logic               m1_n;
  logic               iorq_n;
  logic               int_n;
  logic [7:0]         int_vector;

  // request sources and register access
  logic [NUM_INT-1:0] int_stbs;
  logic               ena_wr;
  logic               req_wr;
  logic [NUM_INT-1:0] wr_mask;
  logic               wr_val;
  logic [NUM_INT-1:0] ena_rd;
  logic [NUM_INT-1:0] req_rd;

  // acknowledge sideband
  logic               ack_stb;
  logic [IDW-1:0]     ack_id;
  logic               ack_spur;

  // controller view
  modport slave (
    input  m1_n, iorq_n, int_stbs, ena_wr, req_wr, wr_mask, wr_val,
    output ena_rd, req_rd, int_n, int_vector, ack_stb, ack_id, ack_spur
  );

  // host / CPU view
  modport master (
    output m1_n, iorq_n, int_stbs, ena_wr, req_wr, wr_mask, wr_val,
    input  ena_rd, req_rd, int_n, int_vector, ack_stb, ack_id, ack_spur
  );
endinterface

// File: rtl/int_ctrl_n.sv
// Z80 IM2 interrupt controller for NUM_INT sources with fixed or rotating
// priority, spurious-vector path and an acknowledge strobe.
module int_ctrl_n #(
  parameter int                 NUM_INT  = 8,
  parameter logic [7:0]         VEC_BASE = 8'hE0,
  parameter logic [7:0]         SPUR_VEC = 8'hFE,
  parameter logic [NUM_INT-1:0] ENA_RST  = '1,
  parameter bit                 ROTATE   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  int_ctrl_n_if.slave bus
);

  localparam int IDW = $clog2(NUM_INT);

  typedef logic [NUM_INT-1:0] vec_t;
  typedef logic [IDW-1:0]     id_t;
  typedef logic [IDW:0]       id_ext_t;

  localparam id_ext_t NUM_ID = id_ext_t'(NUM_INT);

  // --------------------------------------------------------------------------
  // Z80 strobe synchronisers and edge detection
  // --------------------------------------------------------------------------
  logic m1_r, m1_rr, iorq_r, iorq_rr;
  logic m1_beg, inta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1_r    <= 1'b1;
      m1_rr   <= 1'b1;
      iorq_r  <= 1'b1;
      iorq_rr <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values,
      // which is what makes this a two-stage chain rather than one flop.
      m1_r    <= bus.m1_n;
      m1_rr   <= m1_r;
      iorq_r  <= bus.iorq_n;
      iorq_rr <= iorq_r;
    end
  end

  assign m1_beg = m1_rr & ~m1_r;
  // IORQ falling while M1 is already low marks the interrupt acknowledge cycle
  assign inta   = iorq_rr & ~iorq_r & ~m1_rr;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  vec_t req, ena, pend;
  vec_t pri;
  id_t  pri_id;
  id_t  rot_ptr;
  logic int_n;
  logic ack_stb;
  id_t  ack_id;
  logic ack_spur;

  assign pend = req & ena;

  // --------------------------------------------------------------------------
  // Winner search: rotate pend so rot_ptr sits at bit 0, pick the lowest set
  // bit, then rotate the offset back. With ROTATE=0 rot_ptr stays 0.
  // --------------------------------------------------------------------------
  logic [2*NUM_INT-1:0] pend_dbl;
  vec_t                 pend_rot;
  logic                 win_found;
  id_t                  win_off;
  id_ext_t              win_sum;
  id_t                  win_id;
  vec_t                 win_oh;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    pend_dbl  = {pend, pend} >> rot_ptr;
    pend_rot  = pend_dbl[NUM_INT-1:0];
    win_found = 1'b0;
    win_off   = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (pend_rot[i]) begin
        win_found = 1'b1;
        win_off   = id_t'(i);
      end
    end
    win_sum = {1'b0, win_off} + {1'b0, rot_ptr};
    if (win_sum >= NUM_ID) win_sum = win_sum - NUM_ID;
    win_id = win_found ? win_sum[IDW-1:0] : '0;
    win_oh = win_found ? (vec_t'(1) << win_id) : '0;
  end

  // Pointer follows the acknowledged source, wrapping at NUM_INT
  id_ext_t ptr_sum;
  id_t     ptr_next;

  always_comb begin
    ptr_sum = {1'b0, pri_id} + id_ext_t'(1);
    if (ptr_sum >= NUM_ID) ptr_sum = ptr_sum - NUM_ID;
    ptr_next = ptr_sum[IDW-1:0];
  end

  // --------------------------------------------------------------------------
  // Request / enable next state. A strobe outranks its own acknowledge so a
  // new event arriving during INTA is not lost.
  // --------------------------------------------------------------------------
  vec_t req_next, ena_next;

  always_comb begin
    req_next = req;
    ena_next = ena;
    for (int i = 0; i < NUM_INT; i++) begin
      if (bus.int_stbs[i])
        req_next[i] = 1'b1;
      else if (inta && pri[i])
        req_next[i] = 1'b0;
      else if (bus.req_wr && bus.wr_mask[i])
        req_next[i] = bus.wr_val;

      if (bus.ena_wr && bus.wr_mask[i])
        ena_next[i] = bus.wr_val;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req      <= '0;
      ena      <= ENA_RST;
      int_n    <= 1'b1;
      pri      <= '0;
      pri_id   <= '0;
      rot_ptr  <= '0;
      ack_stb  <= 1'b0;
      ack_id   <= '0;
      ack_spur <= 1'b0;
    end else begin
      req     <= req_next;
      ena     <= ena_next;
      int_n   <= ~|pend;
      ack_stb <= inta;

      // Winner is frozen at the start of every M1 so only this cycle's
      // winner can be cleared by the following INTA
      if (m1_beg) begin
        pri    <= win_oh;
        pri_id <= win_id;
      end

      if (inta) begin
        if (|pri) begin
          ack_id   <= pri_id;
          ack_spur <= 1'b0;
          if (ROTATE) rot_ptr <= ptr_next;
        end else begin
          ack_id   <= '0;
          ack_spur <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.int_vector = (|pri) ? (VEC_BASE | 8'({pri_id, 1'b0})) : SPUR_VEC;
  assign bus.int_n      = int_n;
  assign bus.ena_rd     = ena;
  assign bus.req_rd     = req;
  assign bus.ack_stb    = ack_stb;
  assign bus.ack_id     = ack_id;
  assign bus.ack_spur   = ack_spur;

endmodule

// File: tb/tb_int_ctrl_n.sv
// Directed bench for int_ctrl_n: one fixed-priority and one rotating-priority
// instance share the same stimulus; each step checks the relevant instance.
module tb_int_ctrl_n;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         m1_n = 1'b1;
  logic         iorq_n = 1'b1;
  logic [N-1:0] int_stbs = '0;
  logic         ena_wr = 1'b0;
  logic         req_wr = 1'b0;
  logic [N-1:0] wr_mask = '0;
  logic         wr_val = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  int_ctrl_n_if #(.NUM_INT(N)) if_fix ();
  int_ctrl_n_if #(.NUM_INT(N)) if_rot ();

  assign if_fix.m1_n     = m1_n;
  assign if_fix.iorq_n   = iorq_n;
  assign if_fix.int_stbs = int_stbs;
  assign if_fix.ena_wr   = ena_wr;
  assign if_fix.req_wr   = req_wr;
  assign if_fix.wr_mask  = wr_mask;
  assign if_fix.wr_val   = wr_val;

  assign if_rot.m1_n     = m1_n;
  assign if_rot.iorq_n   = iorq_n;
  assign if_rot.int_stbs = int_stbs;
  assign if_rot.ena_wr   = ena_wr;
  assign if_rot.req_wr   = req_wr;
  assign if_rot.wr_mask  = wr_mask;
  assign if_rot.wr_val   = wr_val;

  int_ctrl_n #(.NUM_INT(N), .ROTATE(1'b0)) dut_fix (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_fix)
  );

  int_ctrl_n #(.NUM_INT(N), .ROTATE(1'b1)) dut_rot (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_rot)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    m1_n     = 1'b1;
    iorq_n   = 1'b1;
    int_stbs = '0;
    ena_wr   = 1'b0;
    req_wr   = 1'b0;
    wr_mask  = '0;
    wr_val   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic strobe(input logic [N-1:0] s);
    int_stbs = s;
    tick();
    int_stbs = '0;
  endtask

  task automatic m1_fall();
    m1_n = 1'b0;
    tick();
    tick();
  endtask

  task automatic iorq_fall();
    iorq_n = 1'b0;
    tick();
  endtask

  task automatic bus_release();
    m1_n   = 1'b1;
    iorq_n = 1'b1;
    tick();
    tick();
    tick();
  endtask

  task automatic ena_write(input logic [N-1:0] mask, input logic val);
    ena_wr  = 1'b1;
    wr_mask = mask;
    wr_val  = val;
    tick();
    ena_wr  = 1'b0;
    wr_mask = '0;
    wr_val  = 1'b0;
  endtask

  task automatic req_write(input logic [N-1:0] mask, input logic val);
    req_wr  = 1'b1;
    wr_mask = mask;
    wr_val  = val;
    tick();
    req_wr  = 1'b0;
    wr_mask = '0;
    wr_val  = 1'b0;
  endtask

  // Full INTA on the rotating instance, checking the acknowledged id
  task automatic rot_inta(input string tag, input logic [15:0] exp_id);
    m1_fall();
    iorq_fall();
    tick();
    check({tag, "_stb"}, 16'(if_rot.ack_stb), 16'h1);
    check({tag, "_id"}, 16'(if_rot.ack_id), exp_id);
    check({tag, "_spur"}, 16'(if_rot.ack_spur), 16'h0);
    tick();
    bus_release();
  endtask

  initial begin
    // ---- 1: reset state, single source acknowledge ----
    do_reset();
    check("rst_int_n", 16'(if_fix.int_n), 16'h1);
    check("rst_req", 16'(if_fix.req_rd), 16'h00);
    check("rst_ena", 16'(if_fix.ena_rd), 16'hFF);
    check("rst_ack_stb", 16'(if_fix.ack_stb), 16'h0);
    check("rst_ack_id", 16'(if_fix.ack_id), 16'h0);
    check("rst_ack_spur", 16'(if_fix.ack_spur), 16'h0);
    check("rst_vec", 16'(if_fix.int_vector), 16'hFE);

    strobe(8'h08);
    check("t1_req", 16'(if_fix.req_rd), 16'h08);
    check("t1_int_n_lat", 16'(if_fix.int_n), 16'h1);
    tick();
    check("t1_int_n", 16'(if_fix.int_n), 16'h0);
    m1_fall();
    iorq_fall();
    check("t1_vec", 16'(if_fix.int_vector), 16'hE6);
    check("t1_no_early_ack", 16'(if_fix.ack_stb), 16'h0);
    tick();
    check("t1_ack_stb", 16'(if_fix.ack_stb), 16'h1);
    check("t1_ack_id", 16'(if_fix.ack_id), 16'h3);
    check("t1_ack_spur", 16'(if_fix.ack_spur), 16'h0);
    check("t1_req_clr", 16'(if_fix.req_rd), 16'h00);
    tick();
    check("t1_ack_pulse", 16'(if_fix.ack_stb), 16'h0);
    check("t1_int_n_rel", 16'(if_fix.int_n), 16'h1);
    bus_release();

    // ---- 2: fixed priority, two sources ----
    do_reset();
    strobe(8'h24);
    tick();
    check("t2_int_n", 16'(if_fix.int_n), 16'h0);
    m1_fall();
    iorq_fall();
    check("t2_vec_a", 16'(if_fix.int_vector), 16'hE4);
    tick();
    check("t2_id_a", 16'(if_fix.ack_id), 16'h2);
    check("t2_req_a", 16'(if_fix.req_rd), 16'h20);
    tick();
    check("t2_int_n_a", 16'(if_fix.int_n), 16'h0);
    bus_release();
    m1_fall();
    iorq_fall();
    check("t2_vec_b", 16'(if_fix.int_vector), 16'hEA);
    tick();
    check("t2_id_b", 16'(if_fix.ack_id), 16'h5);
    check("t2_req_b", 16'(if_fix.req_rd), 16'h00);
    tick();
    check("t2_int_n_b", 16'(if_fix.int_n), 16'h1);
    bus_release();

    // ---- 3: rotating priority ----
    do_reset();
    strobe(8'h03);
    tick();
    rot_inta("t3_a0", 16'h0);
    strobe(8'h01);
    tick();
    rot_inta("t3_a1", 16'h1);
    strobe(8'h02);
    tick();
    rot_inta("t3_a2", 16'h0);
    strobe(8'h01);
    tick();
    rot_inta("t3_a3", 16'h1);
    check("t3_req", 16'(if_rot.req_rd), 16'h01);
    // pointer is 2: ch7 beats ch0
    strobe(8'h80);
    tick();
    m1_fall();
    iorq_fall();
    check("t3_vec7", 16'(if_rot.int_vector), 16'hEE);
    tick();
    check("t3_id7", 16'(if_rot.ack_id), 16'h7);
    tick();
    bus_release();
    // pointer wrapped to 0: ch0 beats ch7
    strobe(8'h80);
    tick();
    rot_inta("t3_wrap", 16'h0);
    check("t3_req_end", 16'(if_rot.req_rd), 16'h80);

    // ---- 4: enable drop after M1, then spurious ----
    do_reset();
    strobe(8'h10);
    tick();
    m1_fall();
    ena_write(8'h10, 1'b0);
    check("t4_ena", 16'(if_fix.ena_rd), 16'hEF);
    iorq_fall();
    check("t4_vec", 16'(if_fix.int_vector), 16'hE8);
    check("t4_int_n", 16'(if_fix.int_n), 16'h1);
    tick();
    check("t4_ack_id", 16'(if_fix.ack_id), 16'h4);
    check("t4_req", 16'(if_fix.req_rd), 16'h00);
    tick();
    bus_release();
    m1_fall();
    check("t4_spur_vec", 16'(if_fix.int_vector), 16'hFE);
    iorq_fall();
    tick();
    check("t4_spur_stb", 16'(if_fix.ack_stb), 16'h1);
    check("t4_spur", 16'(if_fix.ack_spur), 16'h1);
    check("t4_spur_id", 16'(if_fix.ack_id), 16'h0);
    tick();
    bus_release();

    // ---- 5: strobe coincident with its own acknowledge ----
    do_reset();
    strobe(8'h02);
    tick();
    m1_fall();
    iorq_fall();
    int_stbs = 8'h02;
    tick();
    int_stbs = '0;
    check("t5_ack_id", 16'(if_fix.ack_id), 16'h1);
    check("t5_req", 16'(if_fix.req_rd), 16'h02);
    tick();
    check("t5_int_n", 16'(if_fix.int_n), 16'h0);
    bus_release();

    // ---- 6: enable / request register writes ----
    do_reset();
    ena_write(8'hFF, 1'b0);
    check("t6_ena0", 16'(if_fix.ena_rd), 16'h00);
    strobe(8'h40);
    tick();
    check("t6_int_n_mask", 16'(if_fix.int_n), 16'h1);
    check("t6_req", 16'(if_fix.req_rd), 16'h40);
    ena_write(8'h40, 1'b1);
    tick();
    check("t6_int_n_en", 16'(if_fix.int_n), 16'h0);
    req_write(8'h40, 1'b0);
    check("t6_req_clr", 16'(if_fix.req_rd), 16'h00);
    tick();
    check("t6_int_n_clr", 16'(if_fix.int_n), 16'h1);
    ena_wr  = 1'b1;
    req_wr  = 1'b1;
    wr_mask = 8'h01;
    wr_val  = 1'b1;
    tick();
    ena_wr  = 1'b0;
    req_wr  = 1'b0;
    wr_mask = '0;
    wr_val  = 1'b0;
    check("t6_both_ena", 16'(if_fix.ena_rd), 16'h41);
    check("t6_both_req", 16'(if_fix.req_rd), 16'h01);
    tick();
    check("t6_both_int_n", 16'(if_fix.int_n), 16'h0);

    // ---- 7: reset asserted mid-INTA ----
    do_reset();
    strobe(8'h01);
    tick();
    m1_fall();
    iorq_fall();
    rst_n = 1'b0;
    #1;
    check("t7_req", 16'(if_fix.req_rd), 16'h00);
    check("t7_int_n", 16'(if_fix.int_n), 16'h1);
    check("t7_vec", 16'(if_fix.int_vector), 16'hFE);
    tick();
    check("t7_ack_stb", 16'(if_fix.ack_stb), 16'h0);
    rst_n  = 1'b1;
    m1_n   = 1'b1;
    iorq_n = 1'b1;
    tick();
    check("t7_ack_after", 16'(if_fix.ack_stb), 16'h0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
